// File: rtl/usb_token_pkg.sv
// Shared types and constants for the USB token decoder.
// Holds the FSM state enum, token PIDs, CRC5 constants and helpers.
package usb_token_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_FIELD,
        ST_CRC,
        ST_WAIT_EOP,
        ST_IGNORE
    } state_e;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;

    localparam logic [4:0] CRC5_PRESET   = 5'b11111;
    localparam logic [4:0] CRC5_POLY     = 5'b00101;
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

    // Index of the last bit in each phase (counter counts from 0).
    localparam logic [3:0] PID_LAST   = 4'd7;
    localparam logic [3:0] FIELD_LAST = 4'd10;
    localparam logic [3:0] CRC_LAST   = 4'd4;

    function automatic logic [4:0] crc5_step(
        input logic [4:0] c,
        input logic       b
    );
        logic fb;
        fb = c[4] ^ b;
        return {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    endfunction

    function automatic logic pid_ok(input logic [7:0] p);
        return p[7:4] == ~p[3:0];
    endfunction

    function automatic logic is_token(input logic [3:0] p);
        return (p == PID_OUT) || (p == PID_IN) || (p == PID_SETUP);
    endfunction

endpackage

// File: rtl/usb_crc5_serial.sv
// Serial CRC5 (x^5+x^2+1) register, one bit per enabled cycle.
// Ports: clk, rst (sync, high), preset, enable, bit_in -> crc[4:0].
module usb_crc5_serial
    import usb_token_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       preset,
    input  logic       enable,
    input  logic       bit_in,
    output logic [4:0] crc
);

    logic [4:0] crc_q;
    logic [4:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (preset) begin
            crc_d = CRC5_PRESET;
        end else if (enable) begin
            crc_d = crc5_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC5_PRESET;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_token_decoder.sv
// USB token packet decoder: PID check, addr/endp capture, CRC5 check.
// In: clk, rst, rx_start, bit_in, bit_valid, eop. Out: token_valid,
// token_err, pid[3:0], addr[6:0], endp[3:0], busy.
module usb_token_decoder
    import usb_token_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_start,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       eop,
    output logic       token_valid,
    output logic       token_err,
    output logic [3:0] pid,
    output logic [6:0] addr,
    output logic [3:0] endp,
    output logic       busy
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  pid_sr_q, pid_sr_d;
    logic [10:0] fld_q, fld_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [3:0]  pid_q, pid_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  endp_q, endp_d;

    logic        crc_preset;
    logic        crc_en;
    logic [4:0]  crc;
    logic [4:0]  crc_res;

    usb_crc5_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .preset (crc_preset),
        .enable (crc_en),
        .bit_in (bit_in),
        .crc    (crc)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pid_sr_d   = pid_sr_q;
        fld_d      = fld_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        pid_d      = pid_q;
        addr_d     = addr_q;
        endp_d     = endp_q;
        crc_preset = 1'b0;
        crc_en     = 1'b0;
        crc_res    = crc;

        if (rx_start) begin
            // A new start always wins, even mid-packet: silent restart.
            state_d = ST_PID;
            cnt_d   = 4'd0;
        end else begin
            // Bit phase first; eop is then judged on the resulting state.
            if (bit_valid) begin
                unique case (state_q)
                    ST_PID: begin
                        pid_sr_d = {bit_in, pid_sr_q[7:1]};
                        cnt_d    = cnt_q + 4'd1;
                        if (cnt_q == PID_LAST) begin
                            cnt_d = 4'd0;
                            if (!pid_ok(pid_sr_d)) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end else if (is_token(pid_sr_d[3:0])) begin
                                state_d    = ST_FIELD;
                                crc_preset = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                    ST_FIELD: begin
                        fld_d  = {bit_in, fld_q[10:1]};
                        crc_en = 1'b1;
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q == FIELD_LAST) begin
                            cnt_d   = 4'd0;
                            state_d = ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        crc_en = 1'b1;
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q == CRC_LAST) begin
                            cnt_d   = 4'd0;
                            state_d = ST_WAIT_EOP;
                        end
                    end
                    ST_WAIT_EOP: begin
                        err_d   = 1'b1;
                        state_d = ST_IGNORE;
                    end
                    default: begin
                    end
                endcase
            end

            // Residual must include a CRC bit arriving with eop.
            if (crc_en) begin
                crc_res = crc5_step(crc, bit_in);
            end

            if (eop) begin
                unique case (state_d)
                    ST_PID, ST_FIELD, ST_CRC: begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                    ST_WAIT_EOP: begin
                        state_d = ST_IDLE;
                        if (crc_res == CRC5_RESIDUAL) begin
                            valid_d = 1'b1;
                            pid_d   = pid_sr_q[3:0];
                            addr_d  = fld_q[6:0];
                            endp_d  = fld_q[10:7];
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ST_IGNORE: begin
                        state_d = ST_IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            pid_sr_q <= 8'd0;
            fld_q    <= 11'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            pid_q    <= 4'd0;
            addr_q   <= 7'd0;
            endp_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pid_sr_q <= pid_sr_d;
            fld_q    <= fld_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            pid_q    <= pid_d;
            addr_q   <= addr_d;
            endp_q   <= endp_d;
        end
    end

    assign token_valid = valid_q;
    assign token_err   = err_q;
    assign pid         = pid_q;
    assign addr        = addr_q;
    assign endp        = endp_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_token_decoder.sv
// Scoreboard bench for usb_token_decoder: directed token cases plus
// randomized packets checked against a packet-level reference model.
module tb_usb_token_decoder;

    logic       clk;
    logic       rst;
    logic       rx_start;
    logic       bit_in;
    logic       bit_valid;
    logic       eop;
    logic       token_valid;
    logic       token_err;
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
    logic       busy;

    usb_token_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .rx_start    (rx_start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .eop         (eop),
        .token_valid (token_valid),
        .token_err   (token_err),
        .pid         (pid),
        .addr        (addr),
        .endp        (endp),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ok;
        logic [3:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
    } exp_t;

    exp_t sbq[$];
    exp_t last;
    bit   pk[$];
    int   total;
    int   passed;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // CRC field value for addr/endp: inverted remainder of the
    // preset-11111 division by x^5+x^2+1, message LSB-first.
    function automatic logic [4:0] ref_crc5(input logic [6:0] a,
                                            input logic [3:0] ep);
        logic [10:0] m;
        int r;
        m = {ep, a};
        r = 'h1F;
        for (int i = 0; i < 11; i++) begin
            if ((((r >> 4) & 1) ^ int'(m[i])) != 0)
                r = ((r << 1) & 'h1F) ^ 'h05;
            else
                r = (r << 1) & 'h1F;
        end
        return 5'(~r);
    endfunction

    // Packet-level outcome from the bit count and field contents.
    function automatic void model(input bit b[$], input bit eop_f,
                                  output bit has, output exp_t e);
        int n;
        logic [7:0] p;
        logic [6:0] a;
        logic [3:0] ep;
        logic [4:0] c;
        n = b.size();
        has = 1'b0;
        e = '0;
        if (n < 8) begin
            has = eop_f;
            return;
        end
        for (int i = 0; i < 8; i++) p[i] = b[i];
        if (p[7:4] != ~p[3:0]) begin
            has = 1'b1;
            return;
        end
        if (!(p[3:0] inside {4'h1, 4'h9, 4'hD})) return;
        if (n > 24) begin
            has = 1'b1;
            return;
        end
        if (!eop_f) return;
        has = 1'b1;
        if (n < 24) return;
        for (int i = 0; i < 7; i++) a[i] = b[8 + i];
        for (int i = 0; i < 4; i++) ep[i] = b[15 + i];
        for (int i = 0; i < 5; i++) c[4 - i] = b[19 + i];
        if (c == ref_crc5(a, ep)) begin
            e.ok   = 1'b1;
            e.pid  = p[3:0];
            e.addr = a;
            e.endp = ep;
        end
    endfunction

    task automatic drive(input logic s, input logic v, input logic b,
                         input logic e);
        rx_start  = s;
        bit_valid = v;
        bit_in    = b;
        eop       = e;
        @(posedge clk);
        #2;
        rx_start  = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        eop       = 1'b0;
    endtask

    task automatic push_lsb(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) pk.push_back(v[i]);
    endtask

    task automatic build_tok(input logic [7:0] p, input logic [6:0] a,
                             input logic [3:0] ep, input logic [4:0] c);
        pk.delete();
        push_lsb(p, 8);
        push_lsb({1'b0, a}, 7);
        push_lsb({4'b0, ep}, 4);
        for (int i = 4; i >= 0; i--) pk.push_back(c[i]);
    endtask

    task automatic send(input bit eop_f, input bit same, input bit gaps);
        int n;
        n = pk.size();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                drive(1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b1, pk[i], eop_f && same && (i == n - 1));
        end
        if (eop_f && (!same || n == 0)) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pkt(input bit eop_f, input bit same, input bit gaps);
        bit   has;
        exp_t e;
        model(pk, eop_f, has, e);
        if (has) sbq.push_back(e);
        send(eop_f, same, gaps);
    endtask

    task automatic expect_ev(input logic ok, input logic [3:0] p,
                             input logic [6:0] a, input logic [3:0] ep);
        exp_t e;
        e.ok   = ok;
        e.pid  = p;
        e.addr = a;
        e.endp = ep;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            last = '0;
        end else if (token_valid === 1'b1 || token_err === 1'b1) begin
            exp_t e;
            chk("exclusive", {31'b0, token_valid & token_err}, 32'd0);
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("kind_valid", {31'b0, token_valid}, {31'b0, e.ok});
                if (e.ok) begin
                    chk("pid", {28'b0, pid}, {28'b0, e.pid});
                    chk("addr", {25'b0, addr}, {25'b0, e.addr});
                    chk("endp", {28'b0, endp}, {28'b0, e.endp});
                    last = e;
                end else begin
                    chk("pid_held", {28'b0, pid}, {28'b0, last.pid});
                    chk("addr_held", {25'b0, addr}, {25'b0, last.addr});
                    chk("endp_held", {28'b0, endp}, {28'b0, last.endp});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pb;
        logic [6:0] a;
        logic [3:0] ep;
        logic [3:0] nib;
        int         kind;
        int         wait_cnt;

        total = 0;
        passed = 0;
        last = '0;
        rst = 1'b1;
        rx_start = 1'b0;
        bit_valid = 1'b0;
        bit_in = 1'b0;
        eop = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, token_valid}, 32'd0);
        chk("rst_err", {31'b0, token_err}, 32'd0);
        chk("rst_pid", {28'b0, pid}, 32'd0);
        chk("rst_addr", {25'b0, addr}, 32'd0);
        chk("rst_endp", {28'b0, endp}, 32'd0);

        // Stray bits and eop before any rx_start are ignored.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // Good OUT token.
        build_tok(8'hE1, 7'h3A, 4'hA, 5'h1C);
        expect_ev(1'b1, 4'b0001, 7'h3A, 4'hA);
        send(1'b1, 1'b0, 1'b0);

        // IN with one CRC bit flipped: error, outputs held.
        build_tok(8'h69, 7'h15, 4'hE, 5'h17 ^ 5'h01);
        expect_ev(1'b0, 4'h0, 7'h0, 4'h0);
        send(1'b1, 1'b0, 1'b0);

        // Same IN with the correct CRC is accepted.
        build_tok(8'h69, 7'h15, 4'hE, 5'h17);
        expect_ev(1'b1, 4'b1001, 7'h15, 4'hE);
        send(1'b1, 1'b1, 1'b0);

        // PID check failure: error after 8th bit, busy drops.
        pb = 8'hE0;
        expect_ev(1'b0, 4'h0, 7'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, pb[i], 1'b0);
        chk("pidfail_busy", {31'b0, busy}, 32'd0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);

        // SETUP short (20 bits) then long (25 bits).
        build_tok(8'h2D, 7'h70, 4'h4, 5'h0E);
        while (pk.size() > 20) void'(pk.pop_back());
        expect_ev(1'b0, 4'h0, 7'h0, 4'h0);
        send(1'b1, 1'b0, 1'b0);
        build_tok(8'h2D, 7'h70, 4'h4, 5'h0E);
        pk.push_back(1'b1);
        expect_ev(1'b0, 4'h0, 7'h0, 4'h0);
        send(1'b1, 1'b0, 1'b0);

        // DATA0 with 16 payload bits: no pulse.
        build_tok(8'hC3, 7'h55, 4'h3, 5'h0A);
        send(1'b1, 1'b0, 1'b0);
        chk("data0_busy", {31'b0, busy}, 32'd0);

        // Reset in the middle of FIELD: discarded, busy low.
        build_tok(8'h2D, 7'h70, 4'h4, 5'h0E);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) drive(1'b0, 1'b1, pk[i], 1'b0);
        chk("midfield_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_pid", {28'b0, pid}, 32'd0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);

        // rx_start mid-FIELD aborts, then a good IN is accepted once.
        build_tok(8'hE1, 7'h11, 4'h2, 5'h00);
        while (pk.size() > 14) void'(pk.pop_back());
        send(1'b0, 1'b0, 1'b0);
        build_tok(8'h69, 7'h3A, 4'hA, 5'h1C);
        expect_ev(1'b1, 4'b1001, 7'h3A, 4'hA);
        send(1'b1, 1'b0, 1'b0);

        // Randomized packets against the reference model.
        repeat (150) begin
            kind = $urandom_range(0, 5);
            a  = 7'($urandom);
            ep = 4'($urandom);
            case ($urandom_range(0, 2))
                0: pb = 8'hE1;
                1: pb = 8'h69;
                default: pb = 8'h2D;
            endcase
            if (kind == 4) pb = 8'($urandom);
            if (kind == 5) begin
                nib = 4'($urandom);
                while (nib inside {4'h1, 4'h9, 4'hD}) nib = 4'($urandom);
                pb = {~nib, nib};
            end
            build_tok(pb, a, ep, ref_crc5(a, ep));
            if (kind == 1) begin
                pk[19 + $urandom_range(0, 4)] ^= 1'b1;
            end else if (kind == 2) begin
                int keep;
                keep = $urandom_range(1, 23);
                while (pk.size() > keep) void'(pk.pop_back());
            end else if (kind == 3) begin
                repeat ($urandom_range(1, 4)) pk.push_back(1'($urandom));
            end
            pkt(1'b1, 1'($urandom), 1'($urandom));
        end

        wait_cnt = 0;
        while (sbq.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        chk("scoreboard_drained", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/usb_token_decoder.md
USB_TOKEN_DECODER -- requirements
Module: usb_token_decoder

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: rx_start  input  1  one-cycle pulse; next bit_valid carries PID bit 0 (SYNC already stripped).
REQ-005 SHALL have port: bit_in  input  1  destuffed serial data bit, LSB-first per field.
REQ-006 SHALL have port: bit_valid  input  1  bit_in qualifier; at most one bit per cycle.
REQ-007 SHALL have port: eop  input  1  one-cycle end-of-packet strobe.
REQ-008 SHALL have port: token_valid  output  1  one-cycle pulse; token decoded, CRC good.
REQ-009 SHALL have port: token_err  output  1  one-cycle pulse; PID, CRC or length error.
REQ-010 SHALL have port: pid  output  4  PID[3:0] of last accepted token; held until next accept.
REQ-011 SHALL have port: addr  output  7  device address of last accepted token.
REQ-012 SHALL have port: endp  output  4  endpoint of last accepted token.
REQ-013 SHALL have port: busy  output  1  high from rx_start until packet resolution.

Function
REQ-014 SHALL implement FSM states IDLE, PID, FIELD, CRC, WAIT_EOP, IGNORE.
REQ-015 SHALL move IDLE->PID on rx_start; bits without prior rx_start are ignored.
REQ-016 SHALL shift 8 bits in PID; PID check = byte[7:4] == ~byte[3:0].
REQ-017 SHALL, on 8th PID bit: check fail -> token_err, go IDLE; token PID (OUT 0001, IN 1001, SETUP 1101) -> FIELD; any other valid PID -> IGNORE.
REQ-018 SHALL leave IGNORE for IDLE on eop with no output pulse.
REQ-019 SHALL shift 11 bits in FIELD (addr bits 0-6, then endp bits 0-3) and 5 bits in CRC, then enter WAIT_EOP.
REQ-020 SHALL run serial CRC5 (x^5+x^2+1): preset 5'b11111 on entry to FIELD; feed all 16 FIELD+CRC bits; fb = crc[4]^bit; crc = {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b0).
REQ-021 SHALL accept the packet iff residual == 5'b01100 when eop arrives in WAIT_EOP.
REQ-022 SHALL, on eop in WAIT_EOP: good -> token_valid on next cycle, pid/addr/endp updated same edge; bad -> token_err next cycle; then IDLE.
REQ-023 SHALL flag token_err and go IDLE on eop in PID, FIELD or CRC (short packet).
REQ-024 SHALL flag token_err and go IGNORE on bit_valid in WAIT_EOP (long packet).
REQ-025 SHALL, on bit_valid and eop in same cycle, process the bit first, then evaluate eop against the resulting state.
REQ-026 SHALL abort silently on rx_start while busy: restart at PID, no pulse.
REQ-027 SHALL never assert token_valid and token_err in the same cycle.
REQ-028 SHALL keep busy low only in IDLE.

Reset
REQ-029 SHALL on rst force IDLE, CRC 5'b11111, token_valid=0, token_err=0, busy=0, pid=0, addr=0, endp=0.
REQ-030 SHALL on rst mid-packet discard the packet with no pulse; rst overrides all inputs.

Structure
REQ-031 SHALL place FSM state enum, token PID constants, CRC5 preset 5'b11111, polynomial 5'b00101 and residual 5'b01100 in shared package usb_token_pkg.
REQ-032 SHALL implement CRC5 in sub-module usb_crc5_serial (clk, rst, preset, enable, bit_in, crc[4:0]).
REQ-033 SHALL total 120-400 lines of RTL.

Verification
REQ-034 SHALL cover: OUT (PID 0xE1) addr 0x3A endp 0xA CRC 0x1C, eop -> token_valid 1 cycle, pid=0001, addr=0x3A, endp=0xA.
REQ-035 SHALL cover: IN (0x69) addr 0x15 endp 0xE CRC 0x17 with one CRC bit flipped -> token_err, outputs unchanged.
REQ-036 SHALL cover: PID byte 0xE0 (check fail) -> token_err after 8th bit, busy low next cycle.
REQ-037 SHALL cover: SETUP (0x2D) addr 0x70 endp 0x4 CRC 0x0E, eop after 20 bits -> token_err; then 25 bits -> token_err, no token_valid.
REQ-038 SHALL cover: DATA0 (0xC3) plus 16 bits, then eop -> no pulse; rst mid-FIELD -> no pulse, busy=0 next cycle.
REQ-039 SHALL cover: rx_start mid-FIELD, then good IN addr 0x3A endp 0xA CRC 0x1C -> exactly one token_valid.
